// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the register-file write path.
// Holds the datapath width, register-file geometry, default sizing for the
// long-latency result queue, and the queue payload type.
package cpu_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  localparam int DEFAULT_DEPTH      = 2;
  localparam int DEFAULT_STARVE_MAX = 4;

  // One buffered long-unit result: destination register plus data.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Small FIFO that buffers long-latency unit results until the RF write
// port has a free cycle.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   push         write pushEntry at posedge (ignored when full)
//   pushEntry    entry to enqueue
//   pop          drop the head at posedge (ignored when empty)
//   full, empty  occupancy flags
//   head         oldest entry, valid while !empty
module wb_result_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wb_entry_t pushEntry,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output wb_entry_t head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W:0]   count;

  logic doPush;
  logic doPop;

  assign full   = (count == FULL_COUNT);
  assign empty  = (count == '0);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign head   = mem[rdPtr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; the pointers define which entries are live,
  // so clearing the array would only cost reset routing.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushEntry;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port master.
// Merges in-order pipeline writeback with out-of-order long-unit results.
// Long results are queued and drained into idle write-port cycles; a
// starvation counter forces a pipeline WB stall when a queued result has
// waited too long. A pending-destination mask lets decode stall on RAW
// hazards against in-flight long ops.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   pipe_wr_en/addr/data          pipeline writeback request
//   lu_issue_valid/rd             long op issued (sets pending bit)
//   lu_res_valid/ready/rd/data    long-unit result handshake
//   rf_wr_en/addr/data            RF write port (sampled by RF on negedge)
//   pend_mask                     registers awaiting a long-unit result
//   wb_stall                      pipeline must hold its WB instruction
module rf_wb_arbiter
  import cpu_pkg::*;
#(
  parameter int XLEN       = cpu_pkg::XLEN,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int STARVE_MAX = DEFAULT_STARVE_MAX
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_wr_en,
  input  logic [REG_ADDR_W-1:0] pipe_wr_addr,
  input  logic [XLEN-1:0]       pipe_wr_data,
  input  logic                  lu_issue_valid,
  input  logic [REG_ADDR_W-1:0] lu_issue_rd,
  input  logic                  lu_res_valid,
  output logic                  lu_res_ready,
  input  logic [REG_ADDR_W-1:0] lu_res_rd,
  input  logic [XLEN-1:0]       lu_res_data,
  output logic                  rf_wr_en,
  output logic [REG_ADDR_W-1:0] rf_wr_addr,
  output logic [XLEN-1:0]       rf_wr_data,
  output logic [NUM_REGS-1:0]   pend_mask,
  output logic                  wb_stall
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic      qFull;
  logic      qEmpty;
  logic      qPush;
  wb_entry_t qHead;
  wb_entry_t resEntry;

  logic             pipeDrives;
  logic             headDrives;
  logic [CNT_W-1:0] starveCnt;
  logic [NUM_REGS-1:0] pendNext;

  assign lu_res_ready  = !qFull && !rst;
  // rd=0 results are handshaken but discarded: x0 is never written.
  assign qPush         = lu_res_valid && lu_res_ready && (lu_res_rd != '0);
  assign resEntry.rd   = lu_res_rd;
  assign resEntry.data = lu_res_data;

  wb_result_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (qPush),
    .pushEntry(resEntry),
    .pop      (headDrives),
    .full     (qFull),
    .empty    (qEmpty),
    .head     (qHead)
  );

  // Starvation overrides the pipeline, which re-presents its write next cycle.
  assign wb_stall   = (starveCnt >= STARVE_LIM) && !qEmpty;
  assign pipeDrives = !wb_stall && pipe_wr_en && (pipe_wr_addr != '0);
  assign headDrives = !qEmpty && !pipeDrives;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    rf_wr_en   = 1'b0;
    rf_wr_addr = '0;
    rf_wr_data = '0;
    if (!rst) begin
      if (pipeDrives) begin
        rf_wr_en   = 1'b1;
        rf_wr_addr = pipe_wr_addr;
        rf_wr_data = pipe_wr_data;
      end else if (headDrives) begin
        rf_wr_en   = 1'b1;
        rf_wr_addr = qHead.rd;
        rf_wr_data = qHead.data;
      end
    end
  end

  // Counts posedges the head has waited; saturates at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starveCnt <= '0;
    end else if (qEmpty || headDrives) begin
      starveCnt <= '0;
    end else if (starveCnt < STARVE_LIM) begin
      starveCnt <= starveCnt + 1'b1;
    end
  end

  // Clear is applied before set so a newly issued op to the same register
  // keeps its pending bit.
  always_comb begin
    pendNext = pend_mask;
    if (headDrives) pendNext[qHead.rd] = 1'b0;
    if (lu_issue_valid && (lu_issue_rd != '0)) pendNext[lu_issue_rd] = 1'b1;
    pendNext[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_mask <= '0;
    else     pend_mask <= pendNext;
  end

endmodule
